// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide unit for the EX stage.
// Decodes R-type mult/multu/div/divu/mfhi/mflo/mthi/mtlo when {ALUOp1,ALUOp0}=10,
// runs one shift-add or restoring-divide step per clock, and owns HI/LO.
// Ports:
//   clk, rst (sync, active high), flush (abort in-flight op)
//   in_valid, ALUOp1, ALUOp0, funct, rs_val, rt_val : EX-stage instruction
//   busy, stall, done                                : status / pipeline hold
//   hi, lo                                           : HI/LO registers
//   mf_valid, mf_result                              : mfhi/mflo read port
module mdu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             ALUOp1,
  input  logic             ALUOp0,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mf_valid,
  output logic [WIDTH-1:0] mf_result
);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand (mult) or divisor (div) magnitude
  logic [WIDTH-1:0]   rs_raw_q, rs_raw_d; // raw dividend, returned in HI on divide by zero
  logic [2*WIDTH-1:0] acc_q, acc_d;       // product accumulator or {remainder, quotient}
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  // Decode
  logic dec_en, is_md, is_mf, is_mt, accept, op_signed;
  assign dec_en    = in_valid & ALUOp1 & ~ALUOp0;
  assign is_md     = dec_en & (funct[5:2] == 4'b0110);
  assign is_mf     = dec_en & ((funct == F_MFHI) | (funct == F_MFLO));
  assign is_mt     = dec_en & ((funct == F_MTHI) | (funct == F_MTLO));
  assign op_signed = ~funct[0];
  assign accept    = (state_q == S_IDLE) & is_md & ~flush;

  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  assign rs_neg = op_signed & rs_val[WIDTH-1];
  assign rt_neg = op_signed & rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  // Multiply step: add multiplicand to the upper half when the current
  // multiplier bit (acc LSB) is set, then shift right keeping the carry.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift {rem,quo} left, trial-subtract the divisor
  // from the WIDTH+1 bit partial remainder; keep it when non-negative.
  logic [WIDTH:0]     div_rem, div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_rem - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      rs_raw_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opnd_q   <= opnd_d;
      rs_raw_q <= rs_raw_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIXUP;
      S_FIXUP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath next values
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opnd_d   = opnd_q;
    rs_raw_d = rs_raw_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d = funct[1];
          sa_d     = rs_neg;
          sb_d     = rt_neg;
          rs_raw_d = rs_val;
          cnt_d    = '0;
          opnd_d   = funct[1] ? rt_mag : rs_mag;
          acc_d    = {{WIDTH{1'b0}}, (funct[1] ? rs_mag : rt_mag)};
        end else if (is_mt && !flush) begin
          if (funct[1]) lo_d = rs_val;
          else          hi_d = rs_val;
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIXUP: begin
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (opnd_q == '0) begin
            hi_d = rs_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    stall     = busy & (is_md | is_mf | is_mt);
    mf_valid  = ~busy & is_mf;
    mf_result = '0;
    if (mf_valid) mf_result = funct[1] ? lo_q : hi_q;
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule
